fifo_rd_packer: RTL and testbench
=================================

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter DATA_W, 8, byte width of the FIFO read port.
REQ-002 Parameter PACK, 4, bytes per output word; the output word width is DATA_W*PACK.
REQ-003 rd_clk  input  1  single clock (FIFO read-side clock); all logic is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fifo_dout  input  DATA_W  FIFO read data; valid the cycle after fifo_rd_en (1-cycle read latency).
REQ-006 fifo_empty  input  1  FIFO empty flag.
REQ-007 fifo_rd_en  output  1  FIFO read strobe.
REQ-008 flush  input  1  single-cycle request to emit any partial word.
REQ-009 m_data  output  DATA_W*PACK  packed word; the first byte read sits in bits [DATA_W-1:0].
REQ-010 m_keep  output  PACK  byte-lane valid mask for m_data.
REQ-011 m_valid  output  1  output word valid.
REQ-012 m_ready  input  1  downstream accept.
REQ-013 flush_done  output  1  one-cycle pulse when a flush completes.

Function
REQ-014 Internal state: accumulator acc, lane count cnt (0..PACK-1), flag acc_full, in-flight flag rd_pend (= fifo_rd_en registered), output register, FSM {S_FILL, S_FLUSH}.
REQ-015 Read issue: fifo_rd_en = !fifo_empty && state==S_FILL && (cnt+rd_pend < PACK) && (!acc_full || !m_valid || m_ready), forced 0 while rst_n==0.
REQ-016 Capture: each cycle with rd_pend==1, fifo_dout is written into lane cnt of acc, then cnt increments.
REQ-017 Word completion: reaching PACK bytes sets acc_full and clears cnt to 0.
REQ-018 Transfer: when acc_full && (!m_valid || m_ready), the acc word moves to the output register, m_keep = all ones, m_valid = 1, and acc_full clears.
REQ-019 Back-to-back: a byte captured in the same cycle as a transfer lands in lane 0 of the freed acc; no byte is lost or duplicated.
REQ-020 Output handshake: a word is accepted on any cycle with m_valid && m_ready.
REQ-021 m_valid clears after acceptance unless a transfer reloads the register in the same cycle.
REQ-022 While m_valid && !m_ready, m_data and m_keep stay stable.
REQ-023 S_FILL -> S_FLUSH on flush==1.
REQ-024 flush is ignored while in S_FLUSH.
REQ-025 flush and a read-issue condition in the same cycle: the read is suppressed (state change has priority).
REQ-026 S_FLUSH: no reads are issued; the FSM waits for rd_pend==0 and acc_full==0.
REQ-027 S_FLUSH with cnt>0: the partial acc transfers under the REQ-018 rule, with m_keep = (1<<cnt)-1 and unused lanes of m_data = 0; cnt then clears.
REQ-028 S_FLUSH with cnt==0, rd_pend==0 and acc_full==0: flush_done pulses for 1 cycle and the FSM returns to S_FILL.
REQ-029 Flush with no buffered bytes: flush_done occurs 1 cycle after flush and emits no word.
REQ-030 fifo_empty high with rd_pend==1: the in-flight byte is still captured; fifo_empty gates only new reads.
REQ-031 Latency: with m_valid==0, m_valid rises 2 cycles after the rd_pend cycle carrying the last byte of a word (capture, then transfer).

Reset
REQ-032 rst_n low asynchronously clears: acc, cnt, acc_full, rd_pend, m_data=0, m_keep=0, m_valid=0, flush_done=0, FSM=S_FILL; fifo_rd_en=0 immediately.
REQ-033 Reset asserted mid-word or with a read in flight discards all buffered and in-flight bytes; no partial word is emitted after release.
REQ-034 The first byte read after reset release lands in lane 0.

Verification
REQ-035 FIFO holds 0x11,0x22,0x33,0x44; m_ready=1 -> exactly one word m_data=0x44332211, m_keep=4'hF; m_valid high 1 cycle; fifo_rd_en pulsed 4 times.
REQ-036 FIFO holds 8 bytes 0x01..0x08; m_ready=0 -> m_data=0x04030201 held stable, second word in acc, fifo_rd_en low with 0 bytes left; then m_ready=1 -> 0x04030201, then 0x08070605, in order.
REQ-037 FIFO holds 0xAA,0xBB then empties; flush pulse -> m_data=0x0000BBAA, m_keep=4'h3, then flush_done 1-cycle pulse.
REQ-038 flush with no buffered bytes -> flush_done exactly 1 cycle later; m_valid stays 0.
REQ-039 1000 random bytes, random fifo_empty gaps and random m_ready -> output stream matches a golden queue byte-for-byte; every m_keep = 4'hF.
REQ-040 rst_n low after 2 of 4 bytes (0x10,0x20) with a read in flight -> fifo_rd_en=0 and m_valid=0 at once; after release, 0x30,0x40,0x50,0x60 -> single word 0x60504030.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// Bundle between the packer, the FIFO read port it drains and the word-stream consumer.
// master is the packer's view; slave is the view of whatever surrounds it.
interface fifo_rd_packer_if #(
    parameter int DATA_W = 8,
    parameter int PACK   = 4
);
    logic [DATA_W-1:0]      fifo_dout;
    logic                   fifo_empty;
    logic                   fifo_rd_en;
    logic                   flush;
    logic [DATA_W*PACK-1:0] m_data;
    logic [PACK-1:0]        m_keep;
    logic                   m_valid;
    logic                   m_ready;
    logic                   flush_done;

    modport master (
        input  fifo_dout, fifo_empty, flush, m_ready,
        output fifo_rd_en, m_data, m_keep, m_valid, flush_done
    );

    modport slave (
        output fifo_dout, fifo_empty, flush, m_ready,
        input  fifo_rd_en, m_data, m_keep, m_valid, flush_done
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Drains a 1-cycle-latency FIFO read port byte by byte and packs PACK bytes per output word.
// A flush request emits any partial word with a lane mask, then pulses flush_done.
module fifo_rd_packer #(
    parameter int DATA_W = 8,
    parameter int PACK   = 4
) (
    input  logic              rd_clk,
    input  logic              rst_n,
    fifo_rd_packer_if.master  bus
);
    localparam int CNT_W  = $clog2(PACK) + 1;
    localparam int WORD_W = DATA_W * PACK;

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_acc_full;
    logic               r_rd_pend;
    logic [WORD_W-1:0]  r_m_data;
    logic [PACK-1:0]    r_m_keep;
    logic               r_m_valid;

    logic               w_out_free;
    logic               w_xfer_full;
    logic               w_xfer_part;
    logic               w_word_done;
    logic               w_drain_idle;
    logic               w_rd_en;
    logic               w_flush_done;
    logic [CNT_W-1:0]   w_fill_level;
    logic [WORD_W-1:0]  w_acc_word;
    logic [WORD_W-1:0]  w_part_word;
    logic [PACK-1:0]    w_part_keep;

    // Bytes already in the accumulator plus the one still coming back from the FIFO.
    assign w_fill_level = r_cnt + {{(CNT_W-1){1'b0}}, r_rd_pend};
    assign w_out_free   = !r_m_valid || bus.m_ready;
    assign w_word_done  = r_rd_pend && (r_cnt == CNT_W'(PACK - 1));
    assign w_xfer_full  = r_acc_full && w_out_free;
    assign w_drain_idle = !r_rd_pend && !r_acc_full && (r_cnt == '0);
    // A partial word only leaves once the last in-flight byte has landed.
    assign w_xfer_part  = (r_state == S_FLUSH) && !r_rd_pend && !r_acc_full &&
                          (r_cnt != '0) && w_out_free;

    assign w_rd_en = rst_n && !bus.fifo_empty && (r_state == S_FILL) && !bus.flush &&
                     (w_fill_level < CNT_W'(PACK)) && (!r_acc_full || w_out_free);

    genvar gi;
    generate
        for (gi = 0; gi < PACK; gi++) begin : g_lane
            logic [DATA_W-1:0] r_lane;

            always_ff @(posedge rd_clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lane <= '0;
                end else if (r_rd_pend && (r_cnt == CNT_W'(gi))) begin
                    r_lane <= bus.fifo_dout;
                end
            end

            assign w_acc_word[gi*DATA_W +: DATA_W]  = r_lane;
            assign w_part_keep[gi]                  = (CNT_W'(gi) < r_cnt);
            assign w_part_word[gi*DATA_W +: DATA_W] = w_part_keep[gi] ? r_lane : '0;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_flush_done = 1'b0;
        case (r_state)
            S_FILL: begin
                if (bus.flush) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_drain_idle) begin
                    w_flush_done = 1'b1;
                    w_state_next = S_FILL;
                end
            end
            default: begin
                w_state_next = S_FILL;
            end
        endcase
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FILL;
            r_cnt      <= '0;
            r_acc_full <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_m_data   <= '0;
            r_m_keep   <= '0;
            r_m_valid  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rd_pend <= w_rd_en;

            if (r_rd_pend) begin
                r_cnt <= w_word_done ? '0 : r_cnt + CNT_W'(1);
            end else if (w_xfer_part) begin
                r_cnt <= '0;
            end

            // Reads are throttled so a word can never complete while the previous one is still held.
            if (w_word_done) begin
                r_acc_full <= 1'b1;
            end else if (w_xfer_full) begin
                r_acc_full <= 1'b0;
            end

            if (w_xfer_full) begin
                r_m_data  <= w_acc_word;
                r_m_keep  <= '1;
                r_m_valid <= 1'b1;
            end else if (w_xfer_part) begin
                r_m_data  <= w_part_word;
                r_m_keep  <= w_part_keep;
                r_m_valid <= 1'b1;
            end else if (bus.m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_data     = r_m_data;
    assign bus.m_keep     = r_m_keep;
    assign bus.m_valid    = r_m_valid;
    assign bus.flush_done = w_flush_done;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a FIFO model feeds bytes, expected words go into a queue,
// and a monitor compares every accepted output word against it.
module tb_fifo_rd_packer;
    logic clk = 1'b0;
    logic rst_n;

    fifo_rd_packer_if #(.DATA_W(8), .PACK(4)) bus ();

    fifo_rd_packer #(.DATA_W(8), .PACK(4)) dut (
        .rd_clk (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] fifo_q[$];
    int total      = 0;
    int bad        = 0;
    int pop_count  = 0;
    int word_count = 0;
    int done_count = 0;
    logic gap_mode   = 1'b0;
    logic rand_ready = 1'b0;
    logic ready_set  = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_word(input logic [31:0] d, input logic [3:0] k);
        word_t w;
        w.data = d;
        w.keep = k;
        exp_q.push_back(w);
    endtask

    task automatic wait_exp_empty(input string name, input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            tick(1);
            i++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
    endtask

    task automatic wait_flush_done(input int budget, output int cycles);
        cycles = 0;
        while (bus.flush_done !== 1'b1 && cycles < budget) begin
            tick(1);
            cycles++;
        end
    endtask

    // FIFO read port: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.fifo_rd_en === 1'b1) begin
            if (fifo_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL read_while_empty actual=rd_en required=no_read");
            end else begin
                bus.fifo_dout <= fifo_q.pop_front();
                pop_count     <= pop_count + 1;
            end
        end
    end

    always @(negedge clk) begin
        bus.fifo_empty = (fifo_q.size() == 0) || (gap_mode && ($urandom_range(0, 3) == 0));
    end

    always @(posedge clk) begin
        #1;
        bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_set;
    end

    // Monitor: every accepted word is checked against the head of the expected queue.
    always @(negedge clk) begin
        word_t e;
        if (rst_n === 1'b1 && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            word_count++;
            $display("word data=%h keep=%h", bus.m_data, bus.m_keep);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word actual=%h keep=%h required=none", bus.m_data, bus.m_keep);
            end else begin
                e = exp_q.pop_front();
                chk("word_data", bus.m_data, e.data);
                chk("word_keep", {28'b0, bus.m_keep}, {28'b0, e.keep});
            end
        end
        if (rst_n === 1'b1 && bus.flush_done === 1'b1) begin
            done_count++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int w0;
        int d0;
        int cyc;
        logic [31:0] acc;
        logic [7:0]  b;

        rst_n     = 1'b0;
        bus.flush = 1'b0;
        tick(3);
        chk("rst_rd_en",      bus.fifo_rd_en, 0);
        chk("rst_m_valid",    bus.m_valid, 0);
        chk("rst_m_keep",     bus.m_keep, 0);
        chk("rst_m_data",     bus.m_data, 0);
        chk("rst_flush_done", bus.flush_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // one full word, downstream always ready
        p0 = pop_count;
        w0 = word_count;
        exp_word(32'h44332211, 4'hF);
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        fifo_q.push_back(8'h44);
        wait_exp_empty("t1_word", 50);
        tick(3);
        chk("t1_rd_pulses", pop_count - p0, 4);
        chk("t1_word_count", word_count - w0, 1);
        chk("t1_valid_low", bus.m_valid, 0);

        // two words with downstream stalled, then released
        ready_set = 1'b0;
        tick(2);
        p0 = pop_count;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        tick(20);
        chk("t2_valid_held", bus.m_valid, 1);
        chk("t2_data_held",  bus.m_data, 32'h04030201);
        chk("t2_keep_held",  bus.m_keep, 4'hF);
        chk("t2_rd_pulses",  pop_count - p0, 8);
        chk("t2_rd_en_low",  bus.fifo_rd_en, 0);
        tick(5);
        chk("t2_data_stable", bus.m_data, 32'h04030201);
        exp_word(32'h04030201, 4'hF);
        exp_word(32'h08070605, 4'hF);
        ready_set = 1'b1;
        wait_exp_empty("t2_drain", 50);

        // partial word flushed out
        p0 = pop_count;
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        tick(8);
        chk("t3_rd_pulses", pop_count - p0, 2);
        chk("t3_no_word_yet", bus.m_valid, 0);
        exp_word(32'h0000BBAA, 4'h3);
        pulse_flush();
        wait_flush_done(20, cyc);
        chk("t3_done_seen", bus.flush_done, 1);
        chk("t3_done_latency", cyc, 1);
        @(negedge clk);
        #1;
        chk("t3_word_before_done", exp_q.size(), 0);
        tick(1);
        chk("t3_done_pulse", bus.flush_done, 0);

        // flush with nothing buffered
        d0 = done_count;
        w0 = word_count;
        pulse_flush();
        chk("t4_done_next", bus.flush_done, 1);
        chk("t4_no_valid",  bus.m_valid, 0);
        tick(1);
        chk("t4_done_once", bus.flush_done, 0);
        tick(3);
        chk("t4_no_word",    word_count - w0, 0);
        chk("t4_done_count", done_count - d0, 1);

        // reset with one byte captured and one in flight
        p0 = pop_count;
        w0 = word_count;
        fifo_q.push_back(8'h10);
        fifo_q.push_back(8'h20);
        cyc = 0;
        while (pop_count - p0 < 2 && cyc < 20) begin
            tick(1);
            cyc++;
        end
        chk("t5_two_reads", pop_count - p0, 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_rd_en",   bus.fifo_rd_en, 0);
        chk("t5_rst_m_valid", bus.m_valid, 0);
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        exp_word(32'h60504030, 4'hF);
        fifo_q.push_back(8'h30);
        fifo_q.push_back(8'h40);
        fifo_q.push_back(8'h50);
        fifo_q.push_back(8'h60);
        wait_exp_empty("t5_word", 50);
        tick(3);
        chk("t5_word_count", word_count - w0, 1);

        // long random stream with empty gaps and random backpressure
        w0 = word_count;
        acc = '0;
        gap_mode   = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            b = 8'($urandom);
            fifo_q.push_back(b);
            acc[(i % 4) * 8 +: 8] = b;
            if ((i % 4) == 3) exp_word(acc, 4'hF);
        end
        wait_exp_empty("t6_stream", 20000);
        gap_mode   = 1'b0;
        rand_ready = 1'b0;
        ready_set  = 1'b1;
        tick(5);
        chk("t6_words", word_count - w0, 250);
        chk("t6_fifo_drained", fifo_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
